// File: rtl/datamemory_burst_if.sv
// Bus bundle for datamemory_burst: request channel, writeback beat channel,
// fetch beat channel, status and the external trigger level.
interface datamemory_burst_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wb;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  trigger;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  busy;

  modport master (
    output req_valid, req_wb, req_addr, trigger, wb_data, wb_valid,
    input  req_ready, wb_ready, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    input  req_valid, req_wb, req_addr, trigger, wb_data, wb_valid,
    output req_ready, wb_ready, rd_data, rd_valid, rd_last, busy
  );
endinterface

// File: rtl/datamemory_burst.sv
// Byte-addressed data memory serving whole cache lines in bursts.
// A fetch streams LINE_WORDS beats after LATENCY wait cycles; a writeback
// absorbs LINE_WORDS beats, stalling on wb_valid low.
// Optional feature macro DATAMEMORY_BURST_MMIO_EN maps the line holding
// MMIO_ADDR to a read-only trigger register.
// The array is never reset; loading an initial image is left to the
// simulation environment.
module datamemory_burst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] MMIO_ADDR  = 32'h0000_00FC
) (
  input logic               clk,
  input logic               rst,
  datamemory_burst_if.slave bus
);

  localparam int unsigned Bytes     = DATA_WIDTH / 8;
  localparam int unsigned LineBytes = LINE_WORDS * Bytes;
  localparam int unsigned BeatW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LatW      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LineMask = ~ADDR_WIDTH'(LineBytes - 1);

  typedef enum logic [1:0] {StIdle, StWait, StFill, StWback} state_e;

  state_e                state_q, state_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wb_q, wb_d;

  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  is_mmio_line;
  logic                  beat_last;
  logic                  mem_we;

  // Beats never cross the line, so the sum stays inside the decoded space.
  assign beat_addr = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(Bytes);
  assign beat_last = (beat_q == BeatW'(LINE_WORDS - 1));

`ifdef DATAMEMORY_BURST_MMIO_EN
  localparam logic [ADDR_WIDTH-1:0] MmioLine = MMIO_ADDR[ADDR_WIDTH-1:0] & LineMask;
  localparam logic [ADDR_WIDTH-1:0] MmioWord =
    MMIO_ADDR[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(Bytes - 1);

  assign is_mmio_line = (base_q == MmioLine);
  // Trigger line: the register word reads the live trigger, the rest read zero.
  assign rd_word = !is_mmio_line ? mem_word :
                   (beat_addr == MmioWord) ? {{(DATA_WIDTH-1){1'b0}}, bus.trigger} :
                   '0;
`else
  assign is_mmio_line = 1'b0;
  assign rd_word      = mem_word;
`endif

  // Asynchronous word read of the current beat, little-endian byte order.
  always_comb begin
    mem_word = '0;
    for (int i = 0; i < int'(Bytes); i++) begin
      mem_word[8*i +: 8] = mem[beat_addr + ADDR_WIDTH'(i)];
    end
  end

  // Array write port; deliberately outside the reset domain so contents survive.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(Bytes); i++) begin
        mem[beat_addr + ADDR_WIDTH'(i)] <= bus.wb_data[8*i +: 8];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      lat_q   <= '0;
      base_q  <= '0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      wb_q    <= wb_d;
    end
  end

  // Next-state logic: accept, count down latency, then stream the line.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    base_d  = base_q;
    wb_d    = wb_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          base_d = bus.req_addr[ADDR_WIDTH-1:0] & LineMask;
          wb_d   = bus.req_wb;
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d = bus.req_wb ? StWback : StFill;
          end else begin
            state_d = StWait;
            lat_d   = LatW'(LATENCY);
          end
        end
      end
      StWait: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LatW'(1)) begin
          state_d = wb_q ? StWback : StFill;
        end
      end
      StFill: begin
        if (beat_last) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StWback: begin
        if (bus.wb_valid) begin
          mem_we = !is_mmio_line;
          if (beat_last) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state only, so reset clears them immediately.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.rd_valid  = (state_q == StFill);
    bus.rd_last   = (state_q == StFill) && beat_last;
    bus.wb_ready  = (state_q == StWback);
    bus.rd_data   = '0;
    if (state_q == StFill) begin
      bus.rd_data = rd_word;
    end
  end

endmodule

// File: tb/tb_datamemory_burst.sv
// Bench for datamemory_burst: directed bursts, a cycle-level reference model
// compared on every falling edge, and literal line contents for each burst.
module tb_datamemory_burst;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 17;
  localparam int unsigned LW    = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned LINEB = LW * BYTES;
  localparam int unsigned AMASK = (1 << AW) - 1;
  localparam int unsigned MMIO  = 32'h0000_00FC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datamemory_burst_if #(.DATA_WIDTH(DW)) bus ();
  datamemory_burst_if #(.DATA_WIDTH(DW)) bus1 ();

  datamemory_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW), .LATENCY(LAT), .MMIO_ADDR(MMIO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  datamemory_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(1), .LATENCY(0), .MMIO_ADDR(MMIO)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (main instance) ----------------
  logic [7:0]  m_mem [1 << AW];
  int          m_phase = 0;  // 0 idle, 1 waiting, 2 data transfer
  bit          m_wb = 1'b0;
  int          m_wait = 0;
  int          m_k = 0;
  int unsigned m_base = 0;

  function automatic bit on_mmio_line(input int unsigned a);
`ifdef DATAMEMORY_BURST_MMIO_EN
    return ((a & AMASK & ~(LINEB - 1)) == (MMIO & AMASK & ~(LINEB - 1)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input int unsigned a);
    logic [31:0] w;
    if (on_mmio_line(a)) begin
      return ((a & AMASK) == (MMIO & AMASK & ~(BYTES - 1))) ? {31'b0, bus.trigger} : 32'h0;
    end
    for (int i = 0; i < int'(BYTES); i++) w[8*i +: 8] = m_mem[(a + i) & AMASK];
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_k     <= 0;
      m_wait  <= 0;
    end else begin
      case (m_phase)
        0: if (bus.req_valid) begin
          m_wb   <= bus.req_wb;
          m_base <= bus.req_addr & AMASK & ~(LINEB - 1);
          m_k    <= 0;
          m_wait <= LAT;
          m_phase <= (LAT == 0) ? 2 : 1;
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_phase <= 2;
        end
        default: begin
          if (!m_wb || bus.wb_valid) begin
            if (m_wb && !on_mmio_line(m_base)) begin
              for (int i = 0; i < int'(BYTES); i++)
                m_mem[(m_base + m_k * BYTES + i) & AMASK] <= bus.wb_data[8*i +: 8];
            end
            if (m_k == LW - 1) begin
              m_phase <= 0;
              m_k     <= 0;
            end else begin
              m_k <= m_k + 1;
            end
          end
        end
      endcase
    end
  end

  // Every falling edge: all outputs must match the model.
  always @(negedge clk) begin
    check("req_ready", bus.req_ready, m_phase == 0);
    check("busy", bus.busy, m_phase != 0);
    check("rd_valid", bus.rd_valid, m_phase == 2 && !m_wb);
    check("rd_last", bus.rd_last, m_phase == 2 && !m_wb && m_k == LW - 1);
    check("wb_ready", bus.wb_ready, m_phase == 2 && m_wb);
    check("rd_data", bus.rd_data,
          (m_phase == 2 && !m_wb) ? model_word(m_base + m_k * BYTES) : 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [127:0] line, input bit gap);
    int k = 0;
    int n = 0;
    bit ph = 1'b0;
    bus.req_valid = 1'b1; bus.req_wb = 1'b1; bus.req_addr = addr;
    step();
    bus.req_valid = 1'b0;
    while (k < 4 && n < 50) begin
      if (!bus.wb_ready) begin
        // Beats offered before the write phase must be ignored.
        bus.wb_valid = 1'b1; bus.wb_data = 32'hDEAD_BEEF;
      end else if (gap && ph) begin
        bus.wb_valid = 1'b0; bus.wb_data = 32'hBAD0_0000; ph = 1'b0;
      end else begin
        bus.wb_valid = 1'b1; bus.wb_data = line[32*k +: 32]; k++; ph = 1'b1;
      end
      step();
      n++;
    end
    bus.wb_valid = 1'b0;
    check("wb_beats_taken", k, 4);
  endtask

  task automatic do_fetch(input logic [31:0] addr, output logic [127:0] beats,
                          output int waited, output logic [3:0] lasts);
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_addr = addr;
    step();
    bus.req_valid = 1'b0;
    waited = 0;
    while (!bus.rd_valid && waited < 20) begin
      step();
      waited++;
    end
    for (int k = 0; k < 4; k++) begin
      beats[32*k +: 32] = bus.rd_data;
      lasts[k] = bus.rd_last;
      step();
    end
  endtask

  logic [127:0] beats;
  logic [3:0]   lasts;
  int           waited;
  int           n;
  bit           seen;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_wb = 0; bus.req_addr = 0; bus.trigger = 0;
    bus.wb_data = 0; bus.wb_valid = 0;
    bus1.req_valid = 0; bus1.req_wb = 0; bus1.req_addr = 0; bus1.trigger = 0;
    bus1.wb_data = 0; bus1.wb_valid = 0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_wb_ready", bus.wb_ready, 0);
    check("reset_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    step();

    // Writeback then fetch from the middle of the same line.
    do_wb(32'h0001_0000, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0);
    do_fetch(32'h0001_000C, beats, waited, lasts);
    check("fetch_line", beats, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    check("fetch_wait_cycles", waited, 2);
    check("fetch_last_flags", lasts, 4'b1000);

    // Stalled writeback; upper address bits ignored on the fetch.
    do_wb(32'h0001_0040, {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001}, 1'b1);
    check("gap_busy_after", bus.busy, 0);
    do_fetch(32'hFFFF_0044, beats, waited, lasts);
    check("gap_line", beats, {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001});

    // Top line of the array, with an out-of-range high bit on the fetch.
    do_wb(32'h0001_FFF0, {32'hFEDCBA98, 32'h76543210, 32'h89ABCDEF, 32'h01234567}, 1'b0);
    do_fetch(32'h0003_FFF8, beats, waited, lasts);
    check("top_line", beats, {32'hFEDCBA98, 32'h76543210, 32'h89ABCDEF, 32'h01234567});

    // req_valid held through a fetch.
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_addr = 32'h0001_0000;
    step();
    n = 0; seen = 1'b0;
    while (!(bus.rd_valid && bus.rd_last) && n < 20) begin
      seen |= bus.req_ready;
      step();
      n++;
    end
    check("hold_ready_low", seen, 0);
    check("hold_last_data", bus.rd_data, 32'h44444444);
    step();
    check("hold_idle_after_last", bus.req_ready, 1);
    step();
    check("hold_second_accepted", bus.busy, 1);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.rd_valid && bus.rd_last) && n < 20) begin
      step();
      n++;
    end
    check("hold_second_done", n < 20, 1);
    step();

    // Reset during FILL beat 2.
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_addr = 32'h0001_0000;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rd_valid && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    check("rst_beat2_data", bus.rd_data, 32'h33333333);
    rst = 1'b1;
    #1;
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_last", bus.rd_last, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    step();
    do_fetch(32'h0001_0004, beats, waited, lasts);
    check("rst_refetch", beats, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

`ifdef DATAMEMORY_BURST_MMIO_EN
    bus.trigger = 1'b1;
    do_fetch(32'h0000_00F0, beats, waited, lasts);
    check("mmio_trig1", beats, {32'h00000001, 32'h0, 32'h0, 32'h0});
    bus.trigger = 1'b0;
    do_fetch(32'h0000_00F0, beats, waited, lasts);
    check("mmio_trig0", beats, 128'h0);
    do_wb(32'h0000_00F0, {32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA}, 1'b0);
    bus.trigger = 1'b1;
    do_fetch(32'h0000_00FC, beats, waited, lasts);
    check("mmio_no_write", beats, {32'h00000001, 32'h0, 32'h0, 32'h0});
    bus.trigger = 1'b0;
`else
    bus.trigger = 1'b1;
    do_wb(32'h0000_00F0, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}, 1'b0);
    do_fetch(32'h0000_00F0, beats, waited, lasts);
    check("mmio_plain_mem", beats, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000});
    bus.trigger = 1'b0;
`endif

    // Zero-latency, single-word line instance.
    bus1.req_valid = 1'b1; bus1.req_wb = 1'b1; bus1.req_addr = 32'h0000_0204;
    step();
    bus1.req_valid = 1'b0;
    check("l0_wb_ready", bus1.wb_ready, 1);
    bus1.wb_valid = 1'b0;
    step();
    check("l0_wb_stall", bus1.wb_ready, 1);
    bus1.wb_valid = 1'b1; bus1.wb_data = 32'hA5A5_5A5A;
    step();
    bus1.wb_valid = 1'b0;
    check("l0_wb_done", bus1.busy, 0);
    bus1.req_valid = 1'b1; bus1.req_wb = 1'b0; bus1.req_addr = 32'h0000_0204;
    step();
    bus1.req_valid = 1'b0;
    check("l0_rd_valid", bus1.rd_valid, 1);
    check("l0_rd_last", bus1.rd_last, 1);
    check("l0_rd_data", bus1.rd_data, 32'hA5A5_5A5A);
    step();
    check("l0_idle_after", bus1.rd_valid, 0);
    check("l0_ready_after", bus1.req_ready, 1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamemory_burst.md
DATAMEMORY_BURST -- requirements
Module: datamemory_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 17: byte-address bits actually decoded; the array holds 2**ADDR_WIDTH bytes.
REQ-003 Parameter LINE_WORDS, default 4: words per cache line; power of two, at least 1.
REQ-004 Parameter LATENCY, default 2: access-wait cycles between request acceptance and the first data beat; at least 0.
REQ-005 Parameter MMIO_ADDR, default 32'h000000FC: byte address of the trigger register.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port req_valid, input, 1 bit: a request is presented this cycle.
REQ-009 Port req_ready, output, 1 bit: block can accept a request (high only in IDLE).
REQ-010 Port req_wb, input, 1 bit: request type; 1 = line writeback, 0 = line fetch.
REQ-011 Port req_addr, input, DATA_WIDTH bits: request byte address.
REQ-012 Port trigger, input, 1 bit: external MMIO trigger level.
REQ-013 Port wb_data, input, DATA_WIDTH bits: writeback data beat.
REQ-014 Port wb_valid, input, 1 bit: wb_data holds a valid beat.
REQ-015 Port wb_ready, output, 1 bit: block accepts a writeback beat this cycle.
REQ-016 Port rd_data, output, DATA_WIDTH bits: fetch data beat, little-endian byte order.
REQ-017 Port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-018 Port rd_last, output, 1 bit: marks the final beat of a line.
REQ-019 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 A request is accepted on a rising edge where req_valid and req_ready are both high; req_addr and req_wb are latched at that edge.
- Line base = latched address with its low log2(LINE_WORDS*DATA_WIDTH/8) bits cleared.
REQ-021 FSM states: IDLE, WAIT, FILL, WBACK.
- IDLE to WAIT on accept, with the latency counter loaded with LATENCY.
- If LATENCY = 0, IDLE goes directly to FILL or WBACK.
REQ-022 In WAIT the counter decrements each cycle; at 0 the FSM enters FILL if req_wb = 0, otherwise WBACK.
REQ-023 FILL: one beat per cycle, LINE_WORDS consecutive cycles.
- Beat k returns word (line base + k*DATA_WIDTH/8), addresses ascending.
- rd_valid = 1 on each beat; rd_last = 1 on beat LINE_WORDS-1.
- Next state after the last beat: IDLE.
REQ-024 WBACK: wb_ready = 1 throughout the state.
- Each cycle with wb_valid = 1 writes all DATA_WIDTH/8 bytes of beat k at (line base + k*DATA_WIDTH/8), then increments k.
- A cycle with wb_valid = 0 stalls the state without advancing k.
- After beat LINE_WORDS-1 is written, next state: IDLE.
REQ-025 Address arithmetic wraps modulo 2**ADDR_WIDTH; upper address bits are ignored.
REQ-026 Outside FILL: rd_valid = 0, rd_last = 0, rd_data = 0.
REQ-027 Outside WBACK: wb_ready = 0, and wb_valid is ignored with no memory write.
REQ-028 req_valid while busy is not accepted and has no effect.
REQ-029 A fetch sees every write from any previously completed writeback (read-after-write is ordered).
REQ-030 Memory contents are not initialised by reset; simulation preloads "data.hex" at byte offset 32'h00010000.

Reset
REQ-031 Asserting rst, including mid-burst, immediately forces: state = IDLE, beat counter = 0, latency counter = 0, req_ready = 1, busy = 0, rd_valid = 0, rd_last = 0, rd_data = 0, wb_ready = 0.
REQ-032 Memory array contents survive reset; a writeback aborted by reset leaves its already-written beats in place.

Configuration
REQ-033 Macro DATAMEMORY_BURST_MMIO_EN defined: a fetch whose line base equals the line base of MMIO_ADDR returns {0, trigger} on the beat holding MMIO_ADDR and 0 on every other beat of that line; trigger is sampled each beat.
- A writeback to that line is accepted and completes normally, but writes nothing.
REQ-034 Macro not defined: MMIO_ADDR is ordinary memory, and no trigger logic is synthesised.

Verification
REQ-035 Defaults; writeback to 0x10000 with beats 11111111, 22222222, 33333333, 44444444; then fetch 0x1000C -> after 2 WAIT cycles, rd_data = 11111111, 22222222, 33333333, 44444444 on consecutive cycles, rd_last on the 4th.
REQ-036 Writeback with wb_valid low on alternate cycles -> exactly 4 writes, in order; busy stays high until the 4th beat.
REQ-037 req_valid held high through a fetch -> second request accepted only on the cycle after rd_last; req_ready = 0 throughout.
REQ-038 rst asserted on FILL beat 2 -> rd_valid = 0 in the same cycle and req_ready = 1; a following fetch returns the full line.
REQ-039 MMIO_EN defined, trigger = 1, fetch 0xF0 -> beat 3 = 00000001, beats 0-2 = 0; with trigger = 0, beat 3 = 0.
REQ-040 LATENCY = 0 and LINE_WORDS = 1: fetch -> rd_valid and rd_last in the cycle after acceptance.
